// File: rtl/data_adc_dec.sv
// rtl/data_adc_dec.sv - N-channel sigma-delta bitstream sync and sinc1 decimator with valid/ready frame output
// Optional per-channel clip detection when ADC_CLIPDET_EN is defined.
module data_adc_dec #(
    parameter int NCH         = 6,
    parameter int SYNC_STAGES = 2,
    parameter int DEC_RATIO   = 64,
    parameter int CLIP_LEN    = 32
) (
    input  logic                             mclkin,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [NCH-1:0]                   data_in,
    input  logic                             overrun_clr,
    output logic [NCH-1:0]                   mdat,
    output logic [NCH*$clog2(DEC_RATIO+1)-1:0] sum_data,
    output logic                             sum_valid,
    input  logic                             sum_ready,
    output logic                             overrun,
    output logic [NCH-1:0]                   clip
);
    localparam int SW = $clog2(DEC_RATIO + 1);
    localparam int WW = (DEC_RATIO > 2) ? $clog2(DEC_RATIO) : 1;

    logic [NCH-1:0]    sync_q [SYNC_STAGES];
    logic [WW-1:0]     wcnt;
    logic [SW-1:0]     acc [NCH];
    logic [NCH*SW-1:0] counts;
    logic              win_end;

    always_ff @(posedge mclkin or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= data_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign mdat    = sync_q[SYNC_STAGES-1];
    assign win_end = en && (wcnt == WW'(DEC_RATIO - 1));

    // Final count folds in the current bit so the next window starts with no lost cycle.
    always_comb begin
        counts = '0;
        for (int c = 0; c < NCH; c++) counts[c*SW +: SW] = acc[c] + SW'(mdat[c]);
    end

    always_ff @(posedge mclkin or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
            sum_data  <= '0;
            sum_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (!en || win_end) begin
                wcnt <= '0;
                for (int c = 0; c < NCH; c++) acc[c] <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
                for (int c = 0; c < NCH; c++) acc[c] <= acc[c] + SW'(mdat[c]);
            end

            if (win_end && (!sum_valid || sum_ready)) begin
                sum_data  <= counts;
                sum_valid <= 1'b1;
            end else if (sum_valid && sum_ready) begin
                sum_valid <= 1'b0;
            end

            if (win_end && sum_valid && !sum_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef ADC_CLIPDET_EN
    localparam int RW = $clog2(CLIP_LEN + 1);

    logic [NCH-1:0] mdat_d;
    logic [RW-1:0]  run [NCH];
    logic [NCH-1:0] clip_q;

    // run holds the length of the current constant stretch, saturating at CLIP_LEN.
    always_ff @(posedge mclkin or negedge rst_n) begin
        if (!rst_n) begin
            mdat_d <= '0;
            clip_q <= '0;
            for (int c = 0; c < NCH; c++) run[c] <= '0;
        end else begin
            mdat_d <= mdat;
            for (int c = 0; c < NCH; c++) begin
                if (mdat[c] != mdat_d[c]) begin
                    run[c]    <= RW'(1);
                    clip_q[c] <= 1'b0;
                end else begin
                    if (run[c] != RW'(CLIP_LEN)) run[c] <= run[c] + 1'b1;
                    clip_q[c] <= (run[c] >= RW'(CLIP_LEN - 1));
                end
            end
        end
    end

    assign clip = clip_q;
`else
    logic unused_clip_len;
    assign unused_clip_len = ^CLIP_LEN;
    assign clip            = '0;
`endif

endmodule

// File: tb/tb_data_adc_dec.sv
// tb/tb_data_adc_dec.sv - directed self-checking bench for data_adc_dec (NCH=6, DEC_RATIO=16, CLIP_LEN=8)
module tb_data_adc_dec;
    logic        mclkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        sum_ready = 1'b0;
    logic [5:0]  data_in = '0;
    logic [5:0]  tog = '0;
    logic [5:0]  d1 = '0;
    logic [5:0]  d2 = '0;
    logic [5:0]  mdat;
    logic [29:0] sum_data;
    logic        sum_valid;
    logic        overrun;
    logic [5:0]  clip;
    int          checks = 0;
    int          errors = 0;

    data_adc_dec #(.NCH(6), .SYNC_STAGES(2), .DEC_RATIO(16), .CLIP_LEN(8)) dut (
        .mclkin(mclkin), .rst_n(rst_n), .en(en), .data_in(data_in),
        .overrun_clr(overrun_clr), .mdat(mdat), .sum_data(sum_data),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .overrun(overrun), .clip(clip)
    );

    always #5 mclkin = ~mclkin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            d2 = d1;
            d1 = data_in;
            @(posedge mclkin);
            #1;
            data_in = data_in ^ tog;
        end
    endtask

    function automatic logic [31:0] fr(input int c0, input int c1, input int c2,
                                       input int c3, input int c4, input int c5);
        return {2'b00, 5'(c5), 5'(c4), 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    initial begin
        #12;
        check("rst_valid", 32'(sum_valid), 0);
        check("rst_data", 32'(sum_data), 0);
        check("rst_mdat", 32'(mdat), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_clip", 32'(clip), 0);
        @(posedge mclkin);
        #1;
        rst_n = 1'b1;

        // constant ch0, always ready
        data_in = 6'b000001;
        step(3);
        check("t1_mdat", 32'(mdat), 32'h01);
        en = 1'b1;
        sum_ready = 1'b1;
        step(15);
        check("t1_lat_pre", 32'(sum_valid), 0);
        step(1);
        check("t1_valid", 32'(sum_valid), 1);
        check("t1_frame", 32'(sum_data), fr(16, 0, 0, 0, 0, 0));
        step(1);
        check("t1_valid_drop", 32'(sum_valid), 0);
        step(15);
        check("t1_valid2", 32'(sum_valid), 1);
        check("t1_frame2", 32'(sum_data), fr(16, 0, 0, 0, 0, 0));
        check("t1_overrun", 32'(overrun), 0);

        // ch2 toggling, mdat lag
        en = 1'b0;
        data_in = 6'b000101;
        tog = 6'b000100;
        step(4);
        check("t2_lag_a", 32'(mdat), 32'(d2));
        en = 1'b1;
        step(16);
        check("t2_valid", 32'(sum_valid), 1);
        check("t2_frame", 32'(sum_data), fr(16, 0, 8, 0, 0, 0));
        check("t2_lag_b", 32'(mdat), 32'(d2));
        step(16);
        check("t2_frame2", 32'(sum_data), fr(16, 0, 8, 0, 0, 0));

        // backpressure across two window ends
        en = 1'b0;
        tog = '0;
        data_in = 6'b100001;
        step(3);
        en = 1'b1;
        sum_ready = 1'b0;
        step(16);
        check("t3_valid", 32'(sum_valid), 1);
        check("t3_frame_a", 32'(sum_data), fr(16, 0, 0, 0, 0, 16));
        data_in = 6'b000010;
        step(8);
        check("t3_stable", 32'(sum_data), fr(16, 0, 0, 0, 0, 16));
        step(8);
        check("t3_held", 32'(sum_data), fr(16, 0, 0, 0, 0, 16));
        check("t3_held_valid", 32'(sum_valid), 1);
        check("t3_overrun", 32'(overrun), 1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("t3_overrun_clr", 32'(overrun), 0);
        sum_ready = 1'b1;
        step(1);
        sum_ready = 1'b0;
        check("t3_accept", 32'(sum_valid), 0);
        step(14);
        check("t3_valid3", 32'(sum_valid), 1);
        check("t3_frame3", 32'(sum_data), fr(0, 16, 0, 0, 0, 0));

        // accept on the exact window-end cycle
        data_in = 6'b000100;
        step(15);
        check("t4_hold", 32'(sum_data), fr(0, 16, 0, 0, 0, 0));
        sum_ready = 1'b1;
        step(1);
        check("t4_valid", 32'(sum_valid), 1);
        check("t4_frame", 32'(sum_data), fr(0, 2, 14, 0, 0, 0));
        check("t4_overrun", 32'(overrun), 0);
        step(1);
        check("t4_valid_drop", 32'(sum_valid), 0);

        // en dropped at wcnt=9
        en = 1'b0;
        data_in = 6'b010001;
        step(3);
        en = 1'b1;
        step(9);
        en = 1'b0;
        step(5);
        check("t5_no_partial", 32'(sum_valid), 0);
        en = 1'b1;
        step(15);
        check("t5_lat_pre", 32'(sum_valid), 0);
        step(1);
        check("t5_valid", 32'(sum_valid), 1);
        check("t5_frame", 32'(sum_data), fr(16, 0, 0, 0, 16, 0));

        // async reset mid-window with a frame pending
        sum_ready = 1'b0;
        step(5);
        check("t6_pending", 32'(sum_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(sum_valid), 0);
        check("t6_data", 32'(sum_data), 0);
        check("t6_mdat", 32'(mdat), 0);
        check("t6_overrun", 32'(overrun), 0);
        @(posedge mclkin);
        #1;
        rst_n = 1'b1;
        step(1);
        check("t6_post", 32'(sum_valid), 0);

        // clip detection on ch4
        en = 1'b0;
        data_in = 6'b000000;
        step(4);
        data_in = 6'b010000;
        step(3);
        check("t7_clip_low", 32'(clip[4]), 0);
        step(8);
`ifdef ADC_CLIPDET_EN
        check("t7_clip_set", 32'(clip[4]), 1);
`else
        check("t7_clip_tied", 32'(clip), 0);
`endif
        data_in = 6'b000000;
        step(3);
        check("t7_clip_clr", 32'(clip[4]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
